parity_frame_ctrl: RTL and testbench

PARITY_FRAME_CTRL -- requirements
Module: parity_frame_ctrl

---
 rtl/parity_ctrl_pkg.sv | 15 +
 rtl/parity_calc.sv | 17 +
 rtl/parity_frame_ctrl.sv | 120 ++++++++++++
 tb/tb_parity_frame_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_ctrl_pkg.sv
// Shared definitions for the parity frame receiver: FSM state encoding and
// default frame/counter widths.
package parity_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        HOLD = 2'd3
    } state_e;

    localparam int DEF_DATA_BITS = 4;
    localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity checker: flags a frame whose data plus parity bit
// disagree with the selected even (mode=0) or odd (mode=1) parity.
module parity_calc
    import parity_ctrl_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic [DATA_BITS-1:0] data,
    input  logic                 par_bit,
    input  logic                 mode,
    output logic                 err
);

    // Folding mode into the reduction turns XOR into XNOR for odd parity.
    assign err = ^{data, par_bit, mode};

endmodule

// File: rtl/parity_frame_ctrl.sv
// Serial frame receiver: collects DATA_BITS strobed bits MSB-first plus a
// parity bit, presents the result until consumed, and counts bad frames.
module parity_frame_ctrl
    import parity_ctrl_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 bit_en,
    input  logic                 din,
    input  logic                 out_ready,
    input  logic                 clr_cnt,
    output logic                 busy,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 par_err,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam int BCW = $clog2(DATA_BITS + 1);

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 mode_q, mode_d;
    logic                 par_err_q, par_err_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic                 calc_err;

    parity_calc #(.DATA_BITS(DATA_BITS)) u_parity_calc (
        .data    (shift_q),
        .par_bit (din),
        .mode    (mode_q),
        .err     (calc_err)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        bit_cnt_d  = bit_cnt_q;
        mode_d     = mode_q;
        par_err_d  = par_err_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = DATA;
                    mode_d    = mode;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_en) begin
                    shift_d   = {shift_q[DATA_BITS-2:0], din};
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                        state_d = PAR;
                    end
                end
            end
            PAR: begin
                // The result registers only move here, so they stay stable
                // through HOLD and keep their values back in IDLE.
                if (bit_en) begin
                    state_d    = HOLD;
                    data_out_d = shift_q;
                    par_err_d  = calc_err;
                    if (calc_err && (err_cnt_q != {CNT_W{1'b1}})) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clr_cnt) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            data_out_q <= '0;
            bit_cnt_q  <= '0;
            mode_q     <= 1'b0;
            par_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            bit_cnt_q  <= bit_cnt_d;
            mode_q     <= mode_d;
            par_err_q  <= par_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == HOLD);
    assign data_out  = data_out_q;
    assign par_err   = par_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Self-checking bench for parity_frame_ctrl: directed and randomized frames
// compared against a parity/count model built from plain arithmetic.
module tb_parity_frame_ctrl;

    localparam int DB = 4;
    localparam int CW = 8;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mode;
    logic          bit_en;
    logic          din;
    logic          out_ready;
    logic          clr_cnt;
    logic          busy;
    logic          out_valid;
    logic [DB-1:0] data_out;
    logic          par_err;
    logic [CW-1:0] err_cnt;

    int total_checks  = 0;
    int passed_checks = 0;

    logic [CW-1:0] exp_cnt;
    logic [DB-1:0] exp_data;
    logic          exp_par;

    always #5 clk = ~clk;

    parity_frame_ctrl #(.DATA_BITS(DB), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .bit_en    (bit_en),
        .din       (din),
        .out_ready (out_ready),
        .clr_cnt   (clr_cnt),
        .busy      (busy),
        .out_valid (out_valid),
        .data_out  (data_out),
        .par_err   (par_err),
        .err_cnt   (err_cnt)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total_checks++;
        if (got === want) passed_checks++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    // Error when the total count of ones disagrees with the requested parity.
    function automatic logic frameError(input logic m, input logic [DB-1:0] d, input logic p);
        int ones;
        ones = $countones(d) + int'(p);
        return (ones % 2) != int'(m);
    endfunction

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one complete frame, optionally with strobe gaps, back-pressure,
    // stray start pulses and a counter clear on the parity edge.
    task automatic applyStimulus(input logic m, input logic [DB-1:0] d, input logic p,
                                 input bit gap, input int hold, input bit glitch, input bit clr);
        logic e;
        checkOutput("idle_before_start", busy, 0);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        mode  = 1'($urandom);
        checkOutput("busy_after_start", busy, 1);

        for (int i = 0; i < DB; i++) begin
            if (gap) begin
                bit_en    = 1'b0;
                din       = 1'($urandom);
                start     = glitch;
                out_ready = 1'($urandom);
                tick();
                start = 1'b0;
                checkOutput("gap_busy", busy, 1);
                checkOutput("gap_no_valid", out_valid, 0);
            end
            bit_en    = 1'b1;
            din       = d[DB-1-i];
            start     = glitch && (i > 0);
            out_ready = 1'($urandom);
            tick();
            bit_en    = 1'b0;
            start     = 1'b0;
            out_ready = 1'b0;
            checkOutput("data_busy", busy, 1);
            checkOutput("data_no_valid", out_valid, 0);
            checkOutput("data_out_kept", data_out, exp_data);
        end

        if (gap) begin
            bit_en    = 1'b0;
            din       = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
            checkOutput("par_wait_busy", busy, 1);
            checkOutput("par_wait_no_valid", out_valid, 0);
        end

        bit_en    = 1'b1;
        din       = p;
        out_ready = 1'b0;
        clr_cnt   = clr;
        tick();
        bit_en  = 1'b0;
        clr_cnt = 1'b0;

        e        = frameError(m, d, p);
        exp_data = d;
        exp_par  = e;
        if (clr) exp_cnt = '0;
        else if (e && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;

        for (int k = 0; k < hold; k++) begin
            checkOutput("hold_valid", out_valid, 1);
            checkOutput("hold_data", data_out, exp_data);
            checkOutput("hold_par_err", par_err, exp_par);
            checkOutput("hold_err_cnt", err_cnt, exp_cnt);
            start     = glitch;
            out_ready = 1'b0;
            tick();
            start = 1'b0;
        end

        checkOutput("result_valid", out_valid, 1);
        checkOutput("result_data", data_out, exp_data);
        checkOutput("result_par_err", par_err, exp_par);
        checkOutput("result_err_cnt", err_cnt, exp_cnt);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("release_no_valid", out_valid, 0);
        checkOutput("release_idle", busy, 0);
        checkOutput("idle_data_kept", data_out, exp_data);
        checkOutput("idle_par_kept", par_err, exp_par);
        checkOutput("idle_err_cnt", err_cnt, exp_cnt);
    endtask

    // Produces a parity bit that makes the frame erroneous.
    function automatic logic badParity(input logic m, input logic [DB-1:0] d);
        return frameError(m, d, 1'b0) ? 1'b0 : 1'b1;
    endfunction

    // Main sequence: reset, directed frames, saturation, mid-frame reset, random.
    initial begin
        logic [DB-1:0] d;
        logic          m;

        reset = 1'b1; start = 1'b0; mode = 1'b0; bit_en = 1'b0;
        din = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        exp_cnt = '0; exp_data = '0; exp_par = 1'b0;

        #2;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_data", data_out, 0);
        checkOutput("reset_par_err", par_err, 0);
        checkOutput("reset_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("idle_ready_ignored", busy, 0);

        applyStimulus(1'b0, 4'b1011, 1'b1, 1'b0, 1, 1'b0, 1'b0);
        checkOutput("even_ok_data", data_out, 4'b1011);
        checkOutput("even_ok_par_err", par_err, 0);
        checkOutput("even_ok_cnt", err_cnt, 0);

        applyStimulus(1'b1, 4'b1100, 1'b0, 1'b0, 1, 1'b0, 1'b0);
        checkOutput("odd_bad_par_err", par_err, 1);
        checkOutput("odd_bad_cnt", err_cnt, 1);

        d = DB'($urandom);
        applyStimulus(1'b0, d, 1'($urandom), 1'b1, 5, 1'b0, 1'b0);

        d = DB'($urandom);
        applyStimulus(1'b1, d, 1'($urandom), 1'b1, 3, 1'b1, 1'b0);

        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        exp_cnt = '0;
        checkOutput("idle_clear", err_cnt, 0);

        for (int n = 0; n < 255; n++) begin
            d = DB'($urandom);
            m = 1'($urandom);
            applyStimulus(m, d, badParity(m, d), 1'b0, 0, 1'b0, 1'b0);
        end
        checkOutput("count_255", err_cnt, 255);
        d = DB'($urandom);
        applyStimulus(1'b0, d, badParity(1'b0, d), 1'b0, 0, 1'b0, 1'b0);
        checkOutput("saturated_256", err_cnt, 255);

        d = DB'($urandom);
        applyStimulus(1'b1, d, badParity(1'b1, d), 1'b0, 1, 1'b0, 1'b1);
        checkOutput("clear_beats_inc", err_cnt, 0);

        d = DB'($urandom);
        applyStimulus(1'b0, d, badParity(1'b0, d), 1'b0, 0, 1'b0, 1'b0);

        start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit_en = 1'b1;
            din    = 1'($urandom);
            tick();
            bit_en = 1'b0;
        end
        reset = 1'b1;
        #1;
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_valid", out_valid, 0);
        checkOutput("midreset_data", data_out, 0);
        checkOutput("midreset_par_err", par_err, 0);
        checkOutput("midreset_err_cnt", err_cnt, 0);
        #1;
        reset    = 1'b0;
        exp_cnt  = '0;
        exp_data = '0;
        exp_par  = 1'b0;
        tick();

        d = DB'($urandom);
        applyStimulus(1'b0, d, 1'($countones(d) % 2), 1'b0, 1, 1'b0, 1'b0);
        checkOutput("post_reset_par_err", par_err, 0);
        checkOutput("post_reset_cnt", err_cnt, 0);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'($urandom), DB'($urandom), 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, 3)), 1'($urandom),
                          ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
